// File: rtl/uart_rx_irr_pkg.sv
// Shared definitions for the UART receive front end.
//   RX_STATE : receiver FSM states (IDLE, START, DATA, STOP)
//   CNT_W    : bit-timing counter width
//   DATA_W   : character width
package lib_uart;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } RX_STATE;
endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO, used only when UART_RX_IRR_FIFO_EN is defined.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and byte (ignored when full and not popping)
//   pop        : read request (ignored when empty)
//   dout       : head byte
//   empty/full : occupancy flags
module uart_rx_fifo
  import lib_uart::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en, rd_en;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (rd_en) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_rx_irr.sv
// 8N1 serial receiver presenting bytes to the CPU as a level request.
//   clk, reset : clock, synchronous active-high reset
//   rxd        : asynchronous serial input, idle high
//   irr        : a received byte is available
//   rx_data    : head byte, valid while irr=1
//   ack        : CPU acknowledge level; rising edge consumes the head byte
//   overrun    : sticky, a completed byte was dropped for lack of space
// Build option: UART_RX_IRR_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead
// of the single holding register.
module uart_rx_irr
  import lib_uart::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  output logic              irr,
  output logic [DATA_W-1:0] rx_data,
  input  logic              ack,
  output logic              overrun
);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535) begin : g_cpb_chk
    $error("CLKS_PER_BIT out of range");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16) begin : g_depth_chk
    $error("FIFO_DEPTH out of range");
  end

  logic              rx_meta, rxs;
  RX_STATE           state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        idx;
  logic [DATA_W-1:0] shreg;
  logic              ack_d;
  logic              push, pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      ack_d   <= 1'b0;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      ack_d   <= ack;
    end
  end

  assign pop  = ack && !ack_d;
  assign push = (state == STOP) && (cnt == '0) && rxs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= HALF_BIT;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rxs) begin
            state <= IDLE;
          end else begin
            cnt   <= FULL_BIT;
            idx   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {rxs, shreg[DATA_W-1:1]};
            cnt   <= FULL_BIT;
            idx   <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          // Byte leaves via push here; a low stop bit simply discards it.
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_IRR_FIFO_EN
  logic              f_empty, f_full;
  logic [DATA_W-1:0] f_dout;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (shreg),
    .pop   (pop),
    .dout  (f_dout),
    .empty (f_empty),
    .full  (f_full)
  );

  assign irr     = !f_empty;
  // FIFO storage is not reset, so hide stale contents while empty.
  assign rx_data = f_empty ? '0 : f_dout;

  always_ff @(posedge clk) begin
    if (reset)                                overrun <= 1'b0;
    else if (push && f_full && !(pop && irr)) overrun <= 1'b1;
  end
`else
  logic              valid;
  logic [DATA_W-1:0] hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      hold    <= '0;
      overrun <= 1'b0;
    end else begin
      if (push && (!valid || pop)) begin
        hold  <= shreg;
        valid <= 1'b1;
      end else if (pop) begin
        valid <= 1'b0;
      end
      if (push && valid && !pop) overrun <= 1'b1;
    end
  end

  assign irr     = valid;
  assign rx_data = hold;
`endif
endmodule
